// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared encodings and the grant-selection helper.  Rev 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GNT_I = 2'd1;
  localparam logic [1:0] ARB_GNT_D = 2'd2;
  localparam logic [1:0] ARB_TURN  = 2'd3;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [3:0] SEL_ALL   = 4'b1111;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // D wins ties unless alternation is enabled and D was the last winner.
  function automatic logic pick_d(input logic i_req, input logic d_req,
                                  input grant_e last, input logic rr_en);
    return d_req && (!i_req || !rr_en || (last == GRANT_I));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : cache request/response ports plus the memory-side port.  Rev 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0] i_addr;
  logic          i_access;
  logic          i_ready;
  logic [DW-1:0] i_rdata;

  logic [AW-1:0] d_addr;
  logic          d_access;
  logic          d_write;
  logic [1:0]    d_size;
  logic [3:0]    d_sel;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] mem_a;
  logic          mem_access;
  logic          mem_write;
  logic [1:0]    mem_size;
  logic [3:0]    mem_sel;
  logic [DW-1:0] mem_st_data;
  logic [DW-1:0] mem_data;
  logic          mem_ready;

  // The arbiter itself
  modport slave (
    input  i_addr, i_access,
    input  d_addr, d_access, d_write, d_size, d_sel, d_wdata,
    input  mem_data, mem_ready,
    output i_ready, i_rdata, d_ready, d_rdata,
    output mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data
  );

  // Caches plus memory side, as seen from outside the arbiter
  modport master (
    output i_addr, i_access,
    output d_addr, d_access, d_write, d_size, d_sel, d_wdata,
    output mem_data, mem_ready,
    input  i_ready, i_rdata, d_ready, d_rdata,
    input  mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_arb_req_reg.sv
// ============================================================================
// mem_arbiter_arb_req_reg : load-enable bank holding the granted request fields.  Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter_arb_req_reg #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic          write_i,
  input  logic [1:0]    size_i,
  input  logic [3:0]    sel_i,
  input  logic [DW-1:0] wdata_i,
  output logic [AW-1:0] addr_o,
  output logic          write_o,
  output logic [1:0]    size_o,
  output logic [3:0]    sel_o,
  output logic [DW-1:0] wdata_o
);

  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [1:0]    size_q;
  logic [3:0]    sel_q;
  logic [DW-1:0] wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else if (load_i) begin
      addr_q  <= addr_i;
      write_q <= write_i;
      size_q  <= size_i;
      sel_q   <= sel_i;
      wdata_q <= wdata_i;
    end
  end

  assign addr_o  = addr_q;
  assign write_o = write_q;
  assign size_o  = size_q;
  assign sel_o   = sel_q;
  assign wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : serialises i-cache and d-cache requests onto one memory port.
// Build option ARB_ROUND_ROBIN_EN alternates the winner on simultaneous requests.  Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  import mem_arbiter_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic [1:0] state_q, state_d;
  logic       mem_access_q, mem_access_d;
  grant_e     last_grant_q, last_grant_d;

  logic          w_any_req;
  logic          w_pick_d;
  logic          w_load;
  logic          w_i_done;
  logic          w_d_done;
  logic [AW-1:0] w_req_addr;
  logic          w_req_write;
  logic [1:0]    w_req_size;
  logic [3:0]    w_req_sel;
  logic [DW-1:0] w_req_wdata;

  assign w_any_req = bus.i_access | bus.d_access;
  assign w_pick_d  = pick_d(bus.i_access, bus.d_access, last_grant_q, RR_EN);

  // Fetches are always full-word reads
  assign w_req_addr  = w_pick_d ? bus.d_addr  : bus.i_addr;
  assign w_req_write = w_pick_d ? bus.d_write : 1'b0;
  assign w_req_size  = w_pick_d ? bus.d_size  : SIZE_WORD;
  assign w_req_sel   = w_pick_d ? bus.d_sel   : SEL_ALL;
  assign w_req_wdata = w_pick_d ? bus.d_wdata : '0;

  always_comb begin
    state_d      = state_q;
    mem_access_d = mem_access_q;
    last_grant_d = last_grant_q;
    w_load       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_load       = 1'b1;
          mem_access_d = 1'b1;
          last_grant_d = w_pick_d ? GRANT_D : GRANT_I;
          state_d      = w_pick_d ? ARB_GNT_D : ARB_GNT_I;
        end
      end
      ARB_GNT_I, ARB_GNT_D: begin
        if (bus.mem_ready) begin
          mem_access_d = 1'b0;
          state_d      = ARB_TURN;
        end
      end
      ARB_TURN: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      mem_access_q <= 1'b0;
      last_grant_q <= GRANT_D;
    end else begin
      state_q      <= state_d;
      mem_access_q <= mem_access_d;
      last_grant_q <= last_grant_d;
    end
  end

  mem_arbiter_arb_req_reg #(
    .AW (AW),
    .DW (DW)
  ) u_arb_req_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_load),
    .addr_i  (w_req_addr),
    .write_i (w_req_write),
    .size_i  (w_req_size),
    .sel_i   (w_req_sel),
    .wdata_i (w_req_wdata),
    .addr_o  (bus.mem_a),
    .write_o (bus.mem_write),
    .size_o  (bus.mem_size),
    .sel_o   (bus.mem_sel),
    .wdata_o (bus.mem_st_data)
  );

  // Completion is steered only to the owner; stray mem_ready outside a grant is dropped
  assign w_i_done = (state_q == ARB_GNT_I) && bus.mem_ready;
  assign w_d_done = (state_q == ARB_GNT_D) && bus.mem_ready;

  assign bus.mem_access = mem_access_q;
  assign bus.i_ready    = w_i_done;
  assign bus.d_ready    = w_d_done;
  assign bus.i_rdata    = w_i_done ? bus.mem_data : '0;
  assign bus.d_rdata    = w_d_done ? bus.mem_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed stimulus with a queued scoreboard for mem_arbiter.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int LAT = 3;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [1:0]  sz;
    logic [3:0]  sel;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    bit          d;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic rst;
  bit   spur;
  bit   model_last;   // 1 = D won last
  int   tests;
  int   fails;
  int   max_starve;

  req_t        exp_req_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] rdq[$];

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_i(input logic [31:0] a, input logic [31:0] rd);
    exp_req_q.push_back('{a: a, w: 1'b0, sz: 2'b10, sel: 4'hF, wd: 32'h0});
    exp_rsp_q.push_back('{d: 1'b0, data: rd});
    rdq.push_back(rd);
  endtask

  task automatic push_d(input logic [31:0] a, input logic w, input logic [1:0] sz,
                        input logic [3:0] sel, input logic [31:0] wd, input logic [31:0] rd);
    exp_req_q.push_back('{a: a, w: w, sz: sz, sel: sel, wd: wd});
    exp_rsp_q.push_back('{d: 1'b1, data: rd});
    rdq.push_back(rd);
  endtask

  task automatic wait_ready(input bit d_side);
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (d_side ? bus.d_ready : bus.i_ready) return;
      cyc++;
      if (cyc > 40) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout: side_d=%0d got no ready, required one within 40 cycles", d_side);
        return;
      end
    end
  endtask

  task automatic wait_grant();
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_access) return;
      cyc++;
      if (cyc > 20) begin
        tests++;
        fails++;
        $display("FAIL grant_timeout: mem_access stayed 0, required 1 within 20 cycles");
        return;
      end
    end
  endtask

  // Simultaneous I fetch and D store; checks order and the single TURN/IDLE gap
  task automatic do_pair(input logic [31:0] ia, input logic [31:0] ird,
                         input logic [31:0] da, input logic [1:0] dsz, input logic [3:0] dsel,
                         input logic [31:0] dwd, input logic [31:0] drd);
    bit first_d;
`ifdef ARB_ROUND_ROBIN_EN
    first_d = (model_last == 1'b0);
`else
    first_d = 1'b1;
`endif
    tick();
    bus.i_addr   = ia;
    bus.i_access = 1'b1;
    bus.d_addr   = da;
    bus.d_write  = 1'b1;
    bus.d_size   = dsz;
    bus.d_sel    = dsel;
    bus.d_wdata  = dwd;
    bus.d_access = 1'b1;
    if (first_d) begin
      push_d(da, 1'b1, dsz, dsel, dwd, drd);
      push_i(ia, ird);
    end else begin
      push_i(ia, ird);
      push_d(da, 1'b1, dsz, dsel, dwd, drd);
    end
    wait_ready(first_d);
    tick();
    if (first_d) bus.d_access = 1'b0;
    else         bus.i_access = 1'b0;
    @(negedge clk); chk("turn_gap", {63'h0, bus.mem_access}, 64'h0);
    @(negedge clk); chk("idle_gap", {63'h0, bus.mem_access}, 64'h0);
    @(negedge clk); chk("second_grant", {63'h0, bus.mem_access}, 64'h1);
    chk("second_grant_addr", {32'h0, bus.mem_a}, {32'h0, (first_d ? ia : da)});
    wait_ready(!first_d);
    tick();
    if (first_d) bus.i_access = 1'b0;
    else         bus.d_access = 1'b0;
    model_last = first_d ? 1'b0 : 1'b1;
  endtask

  // Memory model: answers LAT cycles into each access with the next queued word
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_ready = 1'b0;
      bus.mem_data  = '0;
      if (rst || !bus.mem_access) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          bus.mem_ready = 1'b1;
          bus.mem_data  = (rdq.size() > 0) ? rdq.pop_front() : 32'hDEADBEEF;
        end
      end
      if (spur) begin
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'hAAAA5555;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic prev_acc;
    req_t er;
    rsp_t es;
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_access && !prev_acc) begin
        if (exp_req_q.size() == 0) begin
          chk("unexpected_grant", {63'h0, bus.mem_access}, 64'h0);
        end else begin
          er = exp_req_q.pop_front();
          chk("req_addr",  {32'h0, bus.mem_a}, {32'h0, er.a});
          chk("req_write", {63'h0, bus.mem_write}, {63'h0, er.w});
          chk("req_size",  {62'h0, bus.mem_size}, {62'h0, er.sz});
          chk("req_sel",   {60'h0, bus.mem_sel}, {60'h0, er.sel});
          chk("req_wdata", {32'h0, bus.mem_st_data}, {32'h0, er.wd});
        end
      end
      prev_acc = bus.mem_access;
      if (bus.i_ready || bus.d_ready) begin
        chk("ready_exclusive", {63'h0, bus.i_ready & bus.d_ready}, 64'h0);
        if (exp_rsp_q.size() == 0) begin
          chk("unexpected_ready", {62'h0, bus.i_ready, bus.d_ready}, 64'h0);
        end else begin
          es = exp_rsp_q.pop_front();
          chk("rsp_side",  {63'h0, bus.d_ready}, {63'h0, es.d});
          chk("rsp_rdata", {32'h0, (es.d ? bus.d_rdata : bus.i_rdata)}, {32'h0, es.data});
          chk("other_rdata_zero", {32'h0, (es.d ? bus.i_rdata : bus.d_rdata)}, 64'h0);
        end
      end
    end
  end

  // Longest run of cycles the fetch side waits with no completion
  initial begin
    int cur;
    cur = 0;
    max_starve = 0;
    forever begin
      @(negedge clk);
      if (!rst && bus.i_access && !bus.i_ready) begin
        cur++;
        if (cur > max_starve) max_starve = cur;
      end else begin
        cur = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    spur = 1'b0;
    model_last = 1'b1;
    rst = 1'b1;
    bus.i_addr = '0; bus.i_access = 1'b0;
    bus.d_addr = '0; bus.d_access = 1'b0; bus.d_write = 1'b0;
    bus.d_size = '0; bus.d_sel = '0; bus.d_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_mem_a",    {32'h0, bus.mem_a}, 64'h0);
    chk("rst_ctrl",     {54'h0, bus.mem_access, bus.mem_write, bus.mem_size, bus.mem_sel, bus.i_ready, bus.d_ready}, 64'h0);
    chk("rst_st_data",  {32'h0, bus.mem_st_data}, 64'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Reset while a D store is granted
    tick();
    bus.d_addr = 32'h8000_2000; bus.d_write = 1'b1; bus.d_size = 2'b10;
    bus.d_sel = 4'hF; bus.d_wdata = 32'hCAFE_F00D; bus.d_access = 1'b1;
    exp_req_q.push_back('{a: 32'h8000_2000, w: 1'b1, sz: 2'b10, sel: 4'hF, wd: 32'hCAFE_F00D});
    wait_grant();
    #2 rst = 1'b1;
    #1;
    chk("midrst_access", {63'h0, bus.mem_access}, 64'h0);
    chk("midrst_a",      {32'h0, bus.mem_a}, 64'h0);
    chk("midrst_ctrl",   {56'h0, bus.mem_write, bus.mem_size, bus.mem_sel, bus.d_ready}, 64'h0);
    chk("midrst_data",   {32'h0, bus.mem_st_data}, 64'h0);
    bus.d_access = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("post_rst_idle0", {63'h0, bus.mem_access}, 64'h0);
    @(negedge clk); chk("post_rst_idle1", {63'h0, bus.mem_access}, 64'h0);

    // Single fetch: one-cycle grant latency, forced word/all-strobe fields
    tick();
    bus.i_addr = 32'hBFC0_0000; bus.i_access = 1'b1;
    push_i(32'hBFC0_0000, 32'h3C1D_BFC0);
    @(negedge clk); chk("lat_cycle_n",  {63'h0, bus.mem_access}, 64'h0);
    @(negedge clk); chk("lat_cycle_n1", {63'h0, bus.mem_access}, 64'h1);
    wait_ready(1'b0);
    tick();
    bus.i_access = 1'b0;
    model_last = 1'b0;

    // Tie after an I grant
    do_pair(32'h0000_1000, 32'h1111_0000, 32'h8000_1000, 2'b01, 4'b0011, 32'h0000_1234, 32'h5A5A_0001);

    // D load; requester fields change mid-grant
    tick();
    bus.d_addr = 32'h1000_0040; bus.d_write = 1'b0; bus.d_size = 2'b10;
    bus.d_sel = 4'hF; bus.d_wdata = 32'h0; bus.d_access = 1'b1;
    push_d(32'h1000_0040, 1'b0, 2'b10, 4'hF, 32'h0, 32'h7777_0040);
    wait_grant();
    tick();
    bus.d_addr = 32'hFFFF_FFFC; bus.d_write = 1'b1; bus.d_sel = 4'b0001;
    @(negedge clk);
    chk("hold_addr",  {32'h0, bus.mem_a}, 64'h1000_0040);
    chk("hold_write", {63'h0, bus.mem_write}, 64'h0);
    chk("hold_sel",   {60'h0, bus.mem_sel}, 64'hF);
    wait_ready(1'b1);
    tick();
    bus.d_access = 1'b0;
    model_last = 1'b1;

    // Tie after a D grant
    do_pair(32'h0000_2000, 32'h2222_0000, 32'h8000_1000, 2'b01, 4'b0011, 32'h0000_1234, 32'h5A5A_0002);

    // Stray mem_ready while idle
    tick();
    tick();
    spur = 1'b1;
    @(negedge clk);
    chk("spur_no_ready", {62'h0, bus.i_ready, bus.d_ready}, 64'h0);
    tick();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_state", {63'h0, bus.mem_access}, 64'h0);

    // Back-to-back D loads with a fetch waiting
    tick();
    bus.d_addr = 32'h2000_0000; bus.d_write = 1'b0; bus.d_size = 2'b10;
    bus.d_sel = 4'hF; bus.d_wdata = 32'h0; bus.d_access = 1'b1;
    push_d(32'h2000_0000, 1'b0, 2'b10, 4'hF, 32'h0, 32'hD0D0_0001);
    wait_grant();
    tick();
    bus.i_addr = 32'h0040_0000; bus.i_access = 1'b1;
    push_i(32'h0040_0000, 32'h1111_2222);
    wait_ready(1'b1);
    tick();
    bus.d_access = 1'b0;
    @(negedge clk); chk("b2b_turn", {63'h0, bus.mem_access}, 64'h0);
    @(negedge clk); chk("b2b_idle", {63'h0, bus.mem_access}, 64'h0);
    tick();
    bus.d_addr = 32'h2000_0004; bus.d_access = 1'b1;
    push_d(32'h2000_0004, 1'b0, 2'b10, 4'hF, 32'h0, 32'hD0D0_0002);
    @(negedge clk);
    chk("b2b_i_grant", {63'h0, bus.mem_access}, 64'h1);
    chk("b2b_i_addr",  {32'h0, bus.mem_a}, 64'h0040_0000);
    wait_ready(1'b0);
    tick();
    bus.i_access = 1'b0;
    wait_ready(1'b1);
    tick();
    bus.d_access = 1'b0;

    repeat (4) tick();
    chk("req_queue_empty", 64'(exp_req_q.size()), 64'h0);
    chk("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'h0);
    chk("i_starvation_le8", {63'h0, (max_starve > 8)}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
